// File: rtl/pipeline_batch_feeder_pkg.sv
// rtl/pipeline_batch_feeder_pkg.sv - shared pipeline globals and batch feeder types
package pipeline_batch_feeder_pkg;

  localparam int PCOEFF_COUNT_BITWIDTH = 32;
  localparam int PCOEFF_SUM_BITWIDTH   = PCOEFF_COUNT_BITWIDTH + 35;

  localparam int BOT_W      = 128;
  localparam int PERM_W     = 6;
  localparam int MEM_W      = BOT_W + PERM_W;
  localparam int INFLIGHT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_TERMINATE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/pipeline_batch_feeder_hyperpipe.sv
// rtl/pipeline_batch_feeder_hyperpipe.sv - aligns a read strobe with its memory return
// Data is passed through only when the delayed strobe is set, so idle cycles write zeros.
module pipeline_batch_feeder_hyperpipe #(
  parameter int CYCLES = 2,
  parameter int DATA_W = 134
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CYCLES-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < CYCLES; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[CYCLES-1];
  assign data_o  = valid_o ? data_i : '0;

endmodule

// File: rtl/pipeline_batch_feeder.sv
// rtl/pipeline_batch_feeder.sv - streams batches of bot entries into the pipeline and returns results
module pipeline_batch_feeder
  import pipeline_batch_feeder_pkg::*;
#(
  parameter int READ_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             startBatch,
  input  logic [15:0]                      batchBotCount,
  input  logic [15:0]                      batchBaseAddr,
  output logic                             startAccepted,
  output logic                             memReadEnable,
  output logic [15:0]                      memReadAddr,
  input  logic [MEM_W-1:0]                 memReadData,
  output logic                             writeData,
  output logic [BOT_W-1:0]                 bot,
  output logic [PERM_W-1:0]                validBotPermutes,
  output logic                             batchDone,
  input  logic                             slowDownInput,
  input  logic                             resultsAvailable,
  output logic                             grabResults,
  input  logic [PCOEFF_SUM_BITWIDTH-1:0]   pcoeffSum,
  input  logic [PCOEFF_COUNT_BITWIDTH-1:0] pcoeffCount,
  output logic                             resultValid,
  input  logic                             resultReady,
  output logic [PCOEFF_SUM_BITWIDTH-1:0]   resultSum,
  output logic [PCOEFF_COUNT_BITWIDTH-1:0] resultCount,
  output logic [3:0]                       outstanding,
  output logic                             protocolError
);

  feeder_state_e                    state_q;
  logic [15:0]                      addr_q;
  logic [15:0]                      remaining_q;
  logic                             term_q;
  logic [INFLIGHT_W-1:0]            inflight_q, inflight_d;
  logic [3:0]                       outstanding_q, outstanding_d;
  logic                             error_q, error_d;
  logic                             cap_pending_q;
  logic                             res_valid_q;
  logic [PCOEFF_SUM_BITWIDTH-1:0]   res_sum_q;
  logic [PCOEFF_COUNT_BITWIDTH-1:0] res_count_q;

  logic             accept;
  logic             rd_issue;
  logic             capture;
  logic             drained;
  logic             aligned_valid;
  logic [MEM_W-1:0] aligned_data;

  assign startAccepted = (state_q == ST_IDLE) && (outstanding_q < 4'(MAX_OUTSTANDING));
  assign accept        = startAccepted && startBatch;
  assign rd_issue      = (state_q == ST_STREAM) && !slowDownInput && (remaining_q != '0);
  assign capture       = cap_pending_q;
  assign grabResults   = resultsAvailable && !res_valid_q && !cap_pending_q;
  // The last return may land this very cycle; counting it lets the terminator follow immediately.
  assign drained       = (inflight_q == '0) ||
                         ((inflight_q == INFLIGHT_W'(1)) && aligned_valid);

  pipeline_batch_feeder_hyperpipe #(
    .CYCLES (READ_LATENCY),
    .DATA_W (MEM_W)
  ) u_align (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_issue),
    .data_i  (memReadData),
    .valid_o (aligned_valid),
    .data_o  (aligned_data)
  );

  always_comb begin
    inflight_d    = inflight_q + INFLIGHT_W'(rd_issue) - INFLIGHT_W'(aligned_valid);
    outstanding_d = outstanding_q;
    error_d       = error_q;
    if (capture && (outstanding_q == '0)) begin
      error_d = 1'b1;
    end
    if (accept && !capture) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!accept && capture && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      term_q      <= 1'b0;
    end else begin
      term_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q      <= batchBaseAddr;
            remaining_q <= batchBotCount;
            state_q     <= (batchBotCount == '0) ? ST_TERMINATE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rd_issue) begin
            addr_q      <= addr_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= ST_TERMINATE;
            end
          end
        end
        ST_TERMINATE: begin
          if (drained) begin
            term_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q    <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      cap_pending_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_sum_q     <= '0;
      res_count_q   <= '0;
    end else begin
      inflight_q    <= inflight_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
      cap_pending_q <= grabResults;
      if (capture) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= pcoeffSum;
        res_count_q <= pcoeffCount;
      end else if (res_valid_q && resultReady) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign memReadEnable    = rd_issue;
  assign memReadAddr      = addr_q;
  assign writeData        = aligned_valid | term_q;
  assign batchDone        = term_q;
  assign bot              = aligned_data[MEM_W-1:PERM_W];
  assign validBotPermutes = aligned_data[PERM_W-1:0];
  assign resultValid      = res_valid_q;
  assign resultSum        = res_sum_q;
  assign resultCount      = res_count_q;
  assign outstanding      = outstanding_q;
  assign protocolError    = error_q;

endmodule

// File: tb/tb_pipeline_batch_feeder.sv
// tb/tb_pipeline_batch_feeder.sv - randomized scenario bench for pipeline_batch_feeder
module tb_pipeline_batch_feeder;
  import pipeline_batch_feeder_pkg::*;

  localparam int RL   = 2;
  localparam int MAXO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             rst = 1'b0;
  logic                             startBatch = 1'b0;
  logic [15:0]                      batchBotCount = '0;
  logic [15:0]                      batchBaseAddr = '0;
  logic                             startAccepted;
  logic                             memReadEnable;
  logic [15:0]                      memReadAddr;
  logic [MEM_W-1:0]                 memReadData;
  logic                             writeData;
  logic [BOT_W-1:0]                 bot;
  logic [PERM_W-1:0]                validBotPermutes;
  logic                             batchDone;
  logic                             slowDownInput = 1'b0;
  logic                             resultsAvailable = 1'b0;
  logic                             grabResults;
  logic [PCOEFF_SUM_BITWIDTH-1:0]   pcoeffSum = '0;
  logic [PCOEFF_COUNT_BITWIDTH-1:0] pcoeffCount = '0;
  logic                             resultValid;
  logic                             resultReady = 1'b0;
  logic [PCOEFF_SUM_BITWIDTH-1:0]   resultSum;
  logic [PCOEFF_COUNT_BITWIDTH-1:0] resultCount;
  logic [3:0]                       outstanding;
  logic                             protocolError;

  int          checks  = 0;
  int          errors  = 0;
  int          exp_out = 0;
  logic [31:0] mem_seed = '0;

  pipeline_batch_feeder #(.READ_LATENCY(RL), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .startBatch(startBatch), .batchBotCount(batchBotCount),
    .batchBaseAddr(batchBaseAddr), .startAccepted(startAccepted),
    .memReadEnable(memReadEnable), .memReadAddr(memReadAddr), .memReadData(memReadData),
    .writeData(writeData), .bot(bot), .validBotPermutes(validBotPermutes),
    .batchDone(batchDone), .slowDownInput(slowDownInput),
    .resultsAvailable(resultsAvailable), .grabResults(grabResults),
    .pcoeffSum(pcoeffSum), .pcoeffCount(pcoeffCount), .resultValid(resultValid),
    .resultReady(resultReady), .resultSum(resultSum), .resultCount(resultCount),
    .outstanding(outstanding), .protocolError(protocolError)
  );

  function automatic logic [MEM_W-1:0] mem_word(input logic [15:0] a, input logic [31:0] s);
    logic [127:0] b;
    b = {4{a, ~a}} ^ {4{s}};
    return {b, a[5:0] ^ s[5:0]};
  endfunction

  // Bot memory: content is a function of address, returned RL cycles after the strobe.
  logic [RL-1:0]    pv;
  logic [15:0]      pa [RL];
  logic [MEM_W-1:0] garbage;
  always @(posedge clk) begin
    pv[0] <= memReadEnable;
    pa[0] <= memReadAddr;
    for (int i = 1; i < RL; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    garbage <= {6'($urandom), $urandom, $urandom, $urandom, $urandom};
  end
  assign memReadData = pv[RL-1] ? mem_word(pa[RL-1], mem_seed) : garbage;

  task automatic do_batch(input logic [15:0] base, input logic [15:0] cnt, input int slow_start,
                          input int slow_len, input bit rand_slow, input string tag);
    int reads, dw, terms, run_w, max_run;
    int rdq[$];
    bit slow, done, exp_re;
    logic [15:0] ea;
    logic [MEM_W-1:0] ew;
    reads = 0; dw = 0; terms = 0; run_w = 0; max_run = 0; done = 0;
    mem_seed = $urandom;
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge clk); #1;
      startBatch    = (c == 0);
      batchBotCount = cnt;
      batchBaseAddr = base;
      slow = rand_slow ? ($urandom_range(0, 3) == 0) : (c >= slow_start && c < slow_start + slow_len);
      slowDownInput = slow;
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (startAccepted !== 1'b1) begin
          errors++; $display("FAIL %s_accept got %b want 1", tag, startAccepted);
        end
      end
      exp_re = (c >= 1) && !slow && (reads < int'(cnt));
      ea = base + 16'(reads);
      checks++;
      if (memReadEnable !== exp_re || (exp_re && memReadAddr !== ea)) begin
        errors++;
        $display("FAIL %s_read cyc %0d got en=%b addr=%h want en=%b addr=%h",
                 tag, c, memReadEnable, memReadAddr, exp_re, ea);
      end
      if (memReadEnable === 1'b1) begin
        rdq.push_back(c);
        reads++;
      end
      if (!slow) run_w = 0;
      if (writeData === 1'b1) begin
        if (slow) begin
          run_w++;
          if (run_w > max_run) max_run = run_w;
        end
        checks++;
        if (batchDone === 1'b1) begin
          terms++;
          done = 1;
          if (dw != int'(cnt) || rdq.size() != 0 || bot !== '0 || validBotPermutes !== '0) begin
            errors++;
            $display("FAIL %s_term got writes=%0d bot=%h perm=%h want writes=%0d zero payload",
                     tag, dw, bot, validBotPermutes, cnt);
          end
        end else begin
          ew = mem_word(base + 16'(dw), mem_seed);
          if (rdq.size() == 0) begin
            errors++; $display("FAIL %s_extra_write cyc %0d got write want none", tag, c);
          end else begin
            if ({bot, validBotPermutes} !== ew || c != rdq[0] + RL) begin
              errors++;
              $display("FAIL %s_data idx %0d cyc %0d got %h want %h at cyc %0d",
                       tag, dw, c, {bot, validBotPermutes}, ew, rdq[0] + RL);
            end
            void'(rdq.pop_front());
          end
          dw++;
        end
      end
    end
    startBatch = 1'b0;
    slowDownInput = 1'b0;
    exp_out++;
    checks++;
    if (!done || terms != 1 || reads != int'(cnt) || dw != int'(cnt)) begin
      errors++;
      $display("FAIL %s_totals got done=%0d reads=%0d writes=%0d terms=%0d want reads=writes=%0d terms=1",
               tag, done, reads, dw, terms, cnt);
    end
    checks++;
    if (max_run > RL + 1) begin
      errors++; $display("FAIL %s_trailing got %0d want <= %0d", tag, max_run, RL + 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outstanding !== 4'(exp_out) || startAccepted !== (exp_out < MAXO) || writeData !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got out=%0d acc=%b wr=%b want out=%0d acc=%b wr=0",
               tag, outstanding, startAccepted, writeData, exp_out, exp_out < MAXO);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({writeData, batchDone, memReadEnable, grabResults, resultValid, protocolError, outstanding} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0",
               {writeData, batchDone, memReadEnable, grabResults, resultValid, protocolError, outstanding});
    end
    checks++;
    if ({bot, validBotPermutes, memReadAddr, resultSum, resultCount} !== '0) begin
      errors++; $display("FAIL reset_data got bot=%h sum=%h want 0", bot, resultSum);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (startAccepted !== 1'b1 || outstanding !== 4'd0) begin
      errors++; $display("FAIL reset_idle got acc=%b out=%0d want acc=1 out=0", startAccepted, outstanding);
    end
    exp_out = 0;
  endtask

  task automatic test_basic();
    do_batch(16'h0010, 16'd3, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_zero_count();
    do_batch(16'($urandom), 16'd0, 0, 0, 1'b0, "zero");
  endtask

  task automatic test_results();
    logic [PCOEFF_SUM_BITWIDTH-1:0]   s [2];
    logic [PCOEFF_COUNT_BITWIDTH-1:0] n [2];
    int popped, grabs;
    bit present;
    for (int i = 0; i < 2; i++) begin
      s[i] = {3'($urandom), $urandom, $urandom};
      n[i] = $urandom;
    end
    popped = 0; grabs = 0; present = 0;
    checks++;
    if (outstanding !== 4'd2) begin
      errors++; $display("FAIL res_pre got out=%0d want 2", outstanding);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      resultsAvailable = (popped < 2);
      if (present) begin
        pcoeffSum   = s[popped-1];
        pcoeffCount = n[popped-1];
      end else begin
        pcoeffSum   = {3'($urandom), $urandom, $urandom};
        pcoeffCount = $urandom;
      end
      resultReady = (c == 12 || c == 26);
      @(negedge clk);
      present = 0;
      if (grabResults === 1'b1) begin
        grabs++; popped++; present = 1;
      end
      if (c >= 2 && c <= 12) begin
        checks++;
        if (resultValid !== 1'b1 || resultSum !== s[0] || resultCount !== n[0] || grabResults !== 1'b0) begin
          errors++;
          $display("FAIL res_hold_first cyc %0d got v=%b sum=%h cnt=%h grab=%b want v=1 sum=%h cnt=%h grab=0",
                   c, resultValid, resultSum, resultCount, grabResults, s[0], n[0]);
        end
      end
      if (c == 12) begin
        checks++;
        if (grabs != 1 || outstanding !== 4'd1) begin
          errors++; $display("FAIL res_one_grab got grabs=%0d out=%0d want 1 1", grabs, outstanding);
        end
      end
      if (c == 13) begin
        checks++;
        if (resultValid !== 1'b0 || grabResults !== 1'b1) begin
          errors++; $display("FAIL res_free got v=%b grab=%b want v=0 grab=1", resultValid, grabResults);
        end
      end
      if (c >= 15 && c <= 26) begin
        checks++;
        if (resultValid !== 1'b1 || resultSum !== s[1] || resultCount !== n[1] || outstanding !== 4'd0) begin
          errors++;
          $display("FAIL res_second cyc %0d got v=%b sum=%h cnt=%h out=%0d want v=1 sum=%h cnt=%h out=0",
                   c, resultValid, resultSum, resultCount, outstanding, s[1], n[1]);
        end
      end
      if (c == 28) begin
        checks++;
        if (resultValid !== 1'b0 || grabs != 2 || protocolError !== 1'b0) begin
          errors++;
          $display("FAIL res_end got v=%b grabs=%0d err=%b want v=0 grabs=2 err=0", resultValid, grabs, protocolError);
        end
      end
    end
    resultsAvailable = 1'b0;
    resultReady = 1'b0;
    exp_out = 0;
  endtask

  task automatic test_backpressure();
    do_batch(16'($urandom), 16'd40, 10, 10, 1'b0, "bp");
  endtask

  task automatic test_back_to_back();
    do_batch(16'hFFFE, 16'd5, 0, 0, 1'b1, "wrap");
    for (int i = 0; i < 3; i++) begin
      do_batch(16'($urandom), 16'($urandom_range(1, 20)), 0, 0, 1'b1, "rand");
    end
  endtask

  task automatic test_reset_midstream();
    mem_seed = $urandom;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      startBatch    = (c == 0);
      batchBotCount = 16'd20;
      batchBaseAddr = 16'($urandom);
      slowDownInput = 1'b0;
      rst           = (c != 4);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++;
        if (memReadEnable !== 1'b1) begin
          errors++; $display("FAIL mid_read cyc %0d got %b want 1", c, memReadEnable);
        end
      end
      if (c == 5) begin
        checks++;
        if ({writeData, batchDone, memReadEnable, grabResults, resultValid, protocolError, outstanding} !== 10'b0
            || {bot, validBotPermutes, memReadAddr} !== '0 || startAccepted !== 1'b1) begin
          errors++;
          $display("FAIL mid_reset got wr=%b done=%b re=%b out=%0d addr=%h acc=%b want zeros acc=1",
                   writeData, batchDone, memReadEnable, outstanding, memReadAddr, startAccepted);
        end
      end
      if (c >= 5) begin
        checks++;
        if (writeData !== 1'b0 || memReadEnable !== 1'b0) begin
          errors++; $display("FAIL mid_quiet cyc %0d got wr=%b re=%b want 0 0", c, writeData, memReadEnable);
        end
      end
    end
    startBatch = 1'b0;
    exp_out = 0;
  endtask

  task automatic test_protocol_error();
    resultReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      resultsAvailable = (c == 0);
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (protocolError !== 1'b0 || grabResults !== 1'b1) begin
          errors++; $display("FAIL perr_pre got err=%b grab=%b want 0 1", protocolError, grabResults);
        end
      end
      if (c == 2) begin
        checks++;
        if (protocolError !== 1'b1 || outstanding !== 4'd0 || resultValid !== 1'b1) begin
          errors++;
          $display("FAIL perr_set got err=%b out=%0d v=%b want 1 0 1", protocolError, outstanding, resultValid);
        end
      end
      if (c == 9) begin
        checks++;
        if (protocolError !== 1'b1 || resultValid !== 1'b0 || outstanding !== 4'd0) begin
          errors++;
          $display("FAIL perr_sticky got err=%b v=%b out=%0d want 1 0 0", protocolError, resultValid, outstanding);
        end
      end
    end
    resultReady = 1'b0;
    resultsAvailable = 1'b0;
  endtask

  task automatic test_max_outstanding();
    while (exp_out < MAXO) begin
      do_batch(16'($urandom), 16'd0, 0, 0, 1'b0, "fill");
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      startBatch    = 1'b1;
      batchBotCount = 16'd0;
      @(negedge clk);
      checks++;
      if (startAccepted !== 1'b0 || writeData !== 1'b0 || outstanding !== 4'(MAXO)) begin
        errors++;
        $display("FAIL max_block cyc %0d got acc=%b wr=%b out=%0d want 0 0 %0d",
                 c, startAccepted, writeData, outstanding, MAXO);
      end
    end
    startBatch = 1'b0;
    checks++;
    if (protocolError !== 1'b1) begin
      errors++; $display("FAIL max_err_sticky got %b want 1", protocolError);
    end
  endtask

  task automatic test_final_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (protocolError !== 1'b0 || outstanding !== 4'd0 || startAccepted !== 1'b1) begin
      errors++;
      $display("FAIL final_reset got err=%b out=%0d acc=%b want 0 0 1", protocolError, outstanding, startAccepted);
    end
    exp_out = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_results();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_protocol_error();
    test_max_outstanding();
    test_final_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
